// File: rtl/spi_mem_ctrl.sv
// ---------------------------------------------------------------------------
// spi_mem_ctrl
// SPI master (mode 0) that serves every memory access from the CPU core.
// Each request becomes one complete SPI READ or WRITE transaction:
// 8 command bits, 24 address bits and 8*N data bits, each byte sent MSB-first.
// Address bit 24 picks the chip: 0 = flash (cs1), 1 = RAM (cs2).
//
// Ports
//   clk, rst         system clock, asynchronous active-high reset
//   start_request    level request, sampled in IDLE
//   is_write         1 = write, 0 = read (latched at start)
//   num_bytes        1, 2 or 4 bytes; 3/5/6/7 act as 4, 0 skips the bus
//   target_address   [24] chip select, [23:0] byte address (latched)
//   write_value      store data, little-endian (latched)
//   fetched_value    read data register, bytes shifted in from the top
//   request_done     high in DONE while start_request stays high
//   busy             high in SETUP, SHIFT and HOLD
//   sclk/mosi/miso   SPI bus; cs1/cs2 active-low chip selects
// ---------------------------------------------------------------------------
module spi_mem_ctrl #(
    parameter int         HALF_PERIOD = 1,
    parameter logic [7:0] READ_CMD    = 8'h03,
    parameter logic [7:0] WRITE_CMD   = 8'h02
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_request,
    input  logic        is_write,
    input  logic [2:0]  num_bytes,
    input  logic [24:0] target_address,
    input  logic [31:0] write_value,
    output logic [31:0] fetched_value,
    output logic        request_done,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs1,
    output logic        cs2,
    input  logic        miso
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam int             HP_W    = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(HALF_PERIOD - 1);

    state_t          state;
    state_t          state_nxt;
    logic [HP_W-1:0] hp_cnt;
    logic            phase_hi;
    logic [5:0]      bit_cnt;
    logic [5:0]      last_bit;
    logic [63:0]     tx_sr;
    logic [7:0]      rx_sr;
    logic            wr_q;

    // Sizes other than 0, 1 and 2 are served as a full word.
    function automatic logic [2:0] norm_bytes(input logic [2:0] n);
        case (n)
            3'd0:    norm_bytes = 3'd0;
            3'd1:    norm_bytes = 3'd1;
            3'd2:    norm_bytes = 3'd2;
            default: norm_bytes = 3'd4;
        endcase
    endfunction

    // Index of the final frame bit: 32 header bits plus 8 per data byte.
    function automatic logic [5:0] last_bit_of(input logic [2:0] n);
        case (n)
            3'd1:    last_bit_of = 6'd39;
            3'd2:    last_bit_of = 6'd47;
            default: last_bit_of = 6'd63;
        endcase
    endfunction

    logic [2:0]  req_n;
    logic [63:0] frame;
    logic        half_end;
    logic        frame_end;

    assign req_n     = norm_bytes(num_bytes);
    // Data bytes go out low byte first; unused trailing bytes are never shifted.
    assign frame     = {(is_write ? WRITE_CMD : READ_CMD), target_address[23:0],
                        (is_write ? {write_value[7:0], write_value[15:8],
                                     write_value[23:16], write_value[31:24]}
                                  : 32'h0)};
    assign half_end  = (hp_cnt == HP_LAST);
    assign frame_end = (state == SHIFT) && phase_hi && half_end && (bit_cnt == last_bit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_request) state_nxt = (req_n == 3'd0) ? DONE : SETUP;
            SETUP:   state_nxt = SHIFT;
            SHIFT:   if (frame_end) state_nxt = HOLD;
            HOLD:    state_nxt = DONE;
            DONE:    if (!start_request) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Done is gated by the live request so it drops in the same cycle start does.
    assign request_done = (state == DONE) && start_request;
    assign busy         = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    // Bus outputs are registered so chip select, clock and data never glitch;
    // the async reset still releases the bus the instant rst rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk          <= 1'b0;
            mosi          <= 1'b0;
            cs1           <= 1'b1;
            cs2           <= 1'b1;
            fetched_value <= 32'h0;
            hp_cnt        <= '0;
            phase_hi      <= 1'b0;
            bit_cnt       <= 6'd0;
            last_bit      <= 6'd0;
            tx_sr         <= 64'h0;
            rx_sr         <= 8'h0;
            wr_q          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_request && (req_n != 3'd0)) begin
                        wr_q     <= is_write;
                        last_bit <= last_bit_of(req_n);
                        tx_sr    <= frame;
                        mosi     <= frame[63];
                        sclk     <= 1'b0;
                        cs1      <= target_address[24];
                        cs2      <= ~target_address[24];
                        hp_cnt   <= '0;
                        phase_hi <= 1'b0;
                        bit_cnt  <= 6'd0;
                    end
                end
                SHIFT: begin
                    if (!half_end) begin
                        hp_cnt <= hp_cnt + 1'b1;
                    end else begin
                        hp_cnt <= '0;
                        if (!phase_hi) begin
                            // Rising edge: capture miso as sclk goes high.
                            phase_hi <= 1'b1;
                            sclk     <= 1'b1;
                            rx_sr    <= {rx_sr[6:0], miso};
                            if (!wr_q && bit_cnt[5] && (bit_cnt[2:0] == 3'd7)) begin
                                fetched_value <= {rx_sr[6:0], miso, fetched_value[31:8]};
                            end
                        end else begin
                            // Falling edge: next bit goes out at the start of the low phase.
                            phase_hi <= 1'b0;
                            sclk     <= 1'b0;
                            if (bit_cnt == last_bit) begin
                                cs1  <= 1'b1;
                                cs2  <= 1'b1;
                                mosi <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                                tx_sr   <= {tx_sr[62:0], 1'b0};
                                mosi    <= tx_sr[62];
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
module tb_spi_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        start_a, start_b;
    logic        is_write;
    logic [2:0]  num_bytes;
    logic [24:0] addr;
    logic [31:0] wval;
    logic        miso;

    logic [31:0] fv_a, fv_b;
    logic        done_a, done_b, busy_a, busy_b;
    logic        sclk_a, sclk_b, mosi_a, mosi_b;
    logic        cs1_a, cs1_b, cs2_a, cs2_b;

    spi_mem_ctrl #(.HALF_PERIOD(1)) dut_a (
        .clk(clk), .rst(rst), .start_request(start_a), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(addr), .write_value(wval),
        .fetched_value(fv_a), .request_done(done_a), .busy(busy_a),
        .sclk(sclk_a), .mosi(mosi_a), .cs1(cs1_a), .cs2(cs2_a), .miso(miso)
    );

    spi_mem_ctrl #(.HALF_PERIOD(3)) dut_b (
        .clk(clk), .rst(rst), .start_request(start_b), .is_write(is_write),
        .num_bytes(num_bytes), .target_address(addr), .write_value(wval),
        .fetched_value(fv_b), .request_done(done_b), .busy(busy_b),
        .sclk(sclk_b), .mosi(mosi_b), .cs1(cs1_b), .cs2(cs2_b), .miso(miso)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;

    // SPI slave model: watches whichever DUT is selected.
    bit          sel = 1'b0;
    logic [7:0]  sbytes [4];
    int          rises = 0;
    int          base = 0;
    int          cs1_cnt = 0, cs2_cnt = 0, both_cnt = 0;
    logic [63:0] mosi_bits = 64'h0;
    logic        prev_sclk = 1'b0;

    function automatic logic slave_bit(input int rel);
        int idx;
        logic [7:0] b;
        if (rel < 32 || rel >= 64) return 1'b0;
        idx = rel - 32;
        b = sbytes[idx / 8];
        return b[7 - (idx % 8)];
    endfunction

    always @(negedge clk) begin
        logic bs, bm, bc1, bc2;
        bs  = sel ? sclk_b : sclk_a;
        bm  = sel ? mosi_b : mosi_a;
        bc1 = sel ? cs1_b  : cs1_a;
        bc2 = sel ? cs2_b  : cs2_a;
        if (!bc1) cs1_cnt++;
        if (!bc2) cs2_cnt++;
        if (!bc1 && !bc2) both_cnt++;
        if ((!bc1 || !bc2) && bs && !prev_sclk) begin
            mosi_bits = {mosi_bits[62:0], bm};
            rises++;
        end
        prev_sclk = bs;
        miso = slave_bit(rises - base);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_bytes(input logic [7:0] b0, b1, b2, b3);
        sbytes[0] = b0; sbytes[1] = b1; sbytes[2] = b2; sbytes[3] = b3;
    endtask

    logic [31:0] f_a = 32'h0;
    logic [31:0] f_b = 32'h0;

    task automatic run_txn(input bit use_b, input bit wr, input logic [2:0] nb,
                           input logic [24:0] a, input logic [31:0] wv, input bit drop);
        int n, hp, tot, lat, cycles, c1, c2, cb;
        bit got;
        logic [31:0] fo, fe;
        logic [63:0] es, mask;
        n   = (nb == 3'd0) ? 0 : (nb == 3'd1) ? 1 : (nb == 3'd2) ? 2 : 4;
        hp  = use_b ? 3 : 1;
        tot = (n == 0) ? 0 : 32 + 8 * n;
        lat = (n == 0) ? 1 : 3 + 2 * hp * tot;
        fo  = use_b ? f_b : f_a;
        fe  = fo;
        if (!wr) begin
            if (n == 4) fe = {sbytes[3], sbytes[2], sbytes[1], sbytes[0]};
            else if (n == 2) fe = {sbytes[1], sbytes[0], fo[31:16]};
            else if (n == 1) fe = {sbytes[0], fo[31:8]};
        end
        es = {32'h0, (wr ? 8'h02 : 8'h03), a[23:0]};
        for (int i = 0; i < n; i++) es = (es << 8) | (wr ? 64'(wv[8*i +: 8]) : 64'h0);
        mask = (tot == 64) ? '1 : ((64'd1 << tot) - 64'd1);

        @(negedge clk);
        sel = use_b;
        chk("idle_done", use_b ? done_b : done_a, 1'b0);
        chk("idle_busy", use_b ? busy_b : busy_a, 1'b0);
        is_write = wr; num_bytes = nb; addr = a; wval = wv;
        base = rises; c1 = cs1_cnt; c2 = cs2_cnt; cb = both_cnt;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;

        cycles = 0;
        got = 1'b0;
        while (!got && cycles < 3000) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == 3 && n > 0) begin
                chk("busy_mid", use_b ? busy_b : busy_a, 1'b1);
                is_write = 1'($urandom); num_bytes = 3'($urandom);
                addr = 25'($urandom); wval = $urandom;
            end
            if (drop && cycles == 5) begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (use_b ? done_b : done_a) got = 1'b1;
            if (drop && cycles > 1 && !(use_b ? busy_b : busy_a)) got = 1'b1;
        end
        chk("done_seen", got, 1'b1);
        chk("latency", cycles, lat);
        if (drop) chk("no_done", use_b ? done_b : done_a, 1'b0);
        chk("busy_done", use_b ? busy_b : busy_a, 1'b0);
        chk("sclk_rises", rises - base, tot);
        if (n > 0) chk("mosi_stream", mosi_bits & mask, es);
        chk("cs1_used", (cs1_cnt - c1) > 0, (n > 0) && !a[24]);
        chk("cs2_used", (cs2_cnt - c2) > 0, (n > 0) && a[24]);
        chk("cs_both", both_cnt - cb, 0);
        chk("fetched", use_b ? fv_b : fv_a, fe);
        if (use_b) f_b = fe; else f_a = fe;

        @(negedge clk);
        if (!drop) begin
            start_a = 1'b0; start_b = 1'b0;
            #1;
            chk("done_fall", use_b ? done_b : done_a, 1'b0);
        end
    endtask

    initial begin
        int w;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        is_write = 1'b0; num_bytes = 3'd0; addr = '0; wval = '0;
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        #3;
        chk("rst_sclk", {sclk_a, sclk_b}, 2'b00);
        chk("rst_mosi", {mosi_a, mosi_b}, 2'b00);
        chk("rst_cs", {cs1_a, cs2_a, cs1_b, cs2_b}, 4'b1111);
        chk("rst_fv_a", fv_a, 32'h0);
        chk("rst_fv_b", fv_b, 32'h0);
        chk("rst_busy", {busy_a, busy_b}, 2'b00);
        chk("rst_done", {done_a, done_b}, 2'b00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios.
        set_bytes(8'h13, 8'h00, 8'h00, 8'h93);
        run_txn(0, 0, 3'd4, 25'h0000010, 32'h0, 0);
        set_bytes(8'hA5, 8'h00, 8'h00, 8'h00);
        run_txn(0, 0, 3'd1, 25'h1000004, 32'h0, 0);
        set_bytes(8'h34, 8'h12, 8'h00, 8'h00);
        run_txn(0, 0, 3'd2, 25'h1000004, 32'h0, 0);
        run_txn(0, 1, 3'd2, 25'h1000100, 32'hDEADBEEF, 0);
        set_bytes(8'h11, 8'h22, 8'h33, 8'h44);
        run_txn(0, 0, 3'd4, 25'h0000200, 32'h0, 0);
        run_txn(0, 0, 3'd4, 25'h0000300, 32'h0, 0);
        run_txn(0, 0, 3'd0, 25'h0000400, 32'h0, 0);
        set_bytes(8'h5A, 8'hC3, 8'h0F, 8'hF0);
        run_txn(0, 0, 3'd3, 25'h1ABCDEF, 32'h0, 0);
        run_txn(0, 1, 3'd7, 25'h0123456, 32'h89ABCDEF, 0);
        run_txn(0, 0, 3'd4, 25'h0000040, 32'h0, 1);

        // Asynchronous reset in the middle of the shift phase.
        @(negedge clk);
        sel = 1'b0;
        is_write = 1'b0; num_bytes = 3'd4; addr = 25'h0000080;
        base = rises;
        start_a = 1'b1;
        w = 0;
        while ((rises - base) < 20 && w < 2000) begin
            @(negedge clk);
            w++;
        end
        chk("reach_bit20", (rises - base) >= 20, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_cs", {cs1_a, cs2_a}, 2'b11);
        chk("arst_sclk", sclk_a, 1'b0);
        chk("arst_busy", busy_a, 1'b0);
        chk("arst_done", done_a, 1'b0);
        chk("arst_fv", fv_a, 32'h0);
        f_a = 32'h0; f_b = 32'h0;
        start_a = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        set_bytes(8'h13, 8'h00, 8'h00, 8'h93);
        run_txn(0, 0, 3'd4, 25'h0000010, 32'h0, 0);

        // Slower SPI clock on the second instance.
        run_txn(1, 0, 3'd4, 25'h0000010, 32'h0, 0);

        // Randomized traffic.
        for (int k = 0; k < 12; k++) begin
            set_bytes(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            run_txn(k >= 10, 1'($urandom), 3'($urandom_range(0, 7)),
                    25'($urandom), $urandom, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
Name: spi_mem_ctrl

Overview:
- SPI master that serves every memory access from the rv32e CPU core: instruction fetch, load and store.
- Sits directly downstream of the CPU's fetch/load/store sequencing and drives the external SPI flash (cs1) and SPI RAM (cs2) on uo_out[3:0] / ui_in[0].
- Accepts a level-style start/done handshake, a 25-bit address and a 1/2/4-byte size.
- Performs one complete SPI READ (0x03) or WRITE (0x02) transaction per request.

Parameters:
- HALF_PERIOD, 1, clk cycles per SCLK half-period (>=1); one SPI bit takes 2*HALF_PERIOD clk cycles.
- READ_CMD, 8'h03, opcode sent for reads.
- WRITE_CMD, 8'h02, opcode sent for writes.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- start_request  in  1  level request; sampled in IDLE.
- is_write  in  1  1 = write, 0 = read; latched at start.
- num_bytes  in  3  transfer size in bytes (1, 2 or 4); latched at start.
- target_address  in  25  bit 24 selects the chip; [23:0] is the byte address; latched at start.
- write_value  in  32  store data, little-endian; latched at start.
- fetched_value  out  32  read data register.
- request_done  out  1  transaction complete.
- busy  out  1  high from the start of a transfer until the DONE state is entered.
- sclk  out  1  SPI clock, mode 0, idles low.
- mosi  out  1  SPI data out.
- cs1  out  1  flash chip select, active-low.
- cs2  out  1  RAM chip select, active-low.
- miso  in  1  SPI data in.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, sclk=0, mosi=0, cs1=cs2=1, fetched_value=0, busy=0, bit counters 0.
  - Reset mid-transfer aborts immediately: chip select deasserts in the same cycle; no done is produced.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
- IDLE:
  - On start_request=1, latch all request inputs and go to SETUP; busy=1.
  - If num_bytes=0: go straight to DONE, no chip select, fetched_value unchanged.
  - num_bytes values 3, 5, 6, 7 are treated as 4.
- SETUP (1 clk):
  - Assert cs1 if latched addr[24]=0, otherwise cs2; exactly one chip select is ever low.
  - mosi = first bit; sclk=0.
- SHIFT: frame is 8 command bits, then 24 address bits, then 8*N data bits. All fields go MSB-first per byte.
  - Each bit: sclk low for HALF_PERIOD cycles, then high for HALF_PERIOD cycles.
  - mosi updates at the start of the low phase.
  - miso is sampled on the clk edge that raises sclk.
  - Write data: bytes sent write_value[7:0] first, then [15:8], and so on (little-endian), N bytes.
  - Read data: during the data phase mosi=0. After each complete received byte B, fetched_value <= {B, fetched_value[31:8]}.
    - Result: N=4 gives a little-endian word in [31:0]; N=2 gives the halfword in [31:16]; N=1 gives the byte in [31:24].
    - Low bits hold stale shifted data; the consumer extends from the top.
  - Writes do not modify fetched_value.
- HOLD (1 clk): sclk=0, chip select deasserted, mosi=0.
- DONE:
  - busy=0.
  - request_done = (state==DONE) & start_request, combinational. It must fall in the same cycle start_request falls, so the CPU never sees a stale done on its next request.
  - Stay in DONE while start_request=1; go to IDLE on the first cycle start_request=0.
- start_request dropped mid-transfer: ignored; the transfer completes to DONE, then returns to IDLE with no done pulse.
- Latency (start seen in IDLE to request_done): 1 + 1 + 2*HALF_PERIOD*(32+8N) + 1 cycles.
  - HALF_PERIOD=1, N=4: 131 cycles.
- Address, size and data changes after latching have no effect on the current transfer.

Test Plan:
- Read, addr 25'h000010, N=4, miso model returns bytes 13 00 00 93:
  - cs1 low, cs2 high.
  - mosi stream: 03 00 00 10.
  - fetched_value=32'h93000013; request_done at cycle 131.
  - request_done falls in the same cycle start drops.
- Read, addr 25'h1000004, N=1, miso returns 8'hA5:
  - cs2 low only; address bytes 00 00 04.
  - fetched_value[31:24]=8'hA5; N=2 with bytes 34 12 gives [31:16]=16'h1234.
- Write, addr 25'h1000100, N=2, write_value=32'hDEADBEEF:
  - mosi stream: 02 00 01 00 EF BE (exactly 48 SCLK rising edges).
  - fetched_value unchanged.
- Back-to-back fetch then load, with start dropped for exactly one cycle between requests:
  - Second request starts cleanly.
  - request_done=0 in the gap cycle.
- rst pulsed at SHIFT bit 20:
  - cs1/cs2=1 and sclk=0 immediately (asynchronous).
  - Next request after reset completes normally.
- HALF_PERIOD=3, N=4 read: SCLK period 6 clk; request_done after 387 cycles; data identical to the first test.
